// File: rtl/par_seri_tx.sv
// Parallel-to-serial transmitter: loads a W-bit word and shifts it out MSB first,
// one bit per enabled edge, with a one-cycle done pulse after the last bit.
module par_seri_tx #(
    parameter int unsigned W = 4
) (
    input  logic         ck_i,
    input  logic         res_i,
    input  logic         en_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic         so_o,
    output logic         sv_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntMax = CW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge ck_i) begin
        if (res_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        so_o    = 1'b0;
        sv_o    = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ld_i) begin
                    shift_d = d_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                so_o   = shift_q[W-1];
                sv_o   = en_i;
                busy_o = 1'b1;
                if (en_i) begin
                    shift_d = {shift_q[W-2:0], 1'b0};
                    // Counter saturates at W-1; the last bit moves us to DONE instead.
                    if (cnt_q == CntMax) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                done_o = 1'b1;
                if (ld_i) begin
                    shift_d = d_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_par_seri_tx.sv
// Bench for par_seri_tx: directed vector table for the corner cases, then random
// traffic checked against a bit-queue model of the transmitter.
module tb_par_seri_tx;

    localparam int unsigned W = 4;

    logic         ck;
    logic         res;
    logic         en;
    logic         ld;
    logic [W-1:0] d;
    logic         so;
    logic         sv;
    logic         busy;
    logic         done;

    int n_chk  = 0;
    int n_pass = 0;

    par_seri_tx #(.W(W)) dut (
        .ck_i   (ck),
        .res_i  (res),
        .en_i   (en),
        .ld_i   (ld),
        .d_i    (d),
        .so_o   (so),
        .sv_o   (sv),
        .busy_o (busy),
        .done_o (done)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Model: bits still to send, plus a flag for the pending done cycle.
    bit mq[$];
    bit done_pend;
    bit model_valid = 1'b0;

    typedef struct {
        logic         r;
        logic         l;
        logic         e;
        logic [W-1:0] dd;
        logic [3:0]   exp;  // {so, sv, busy, done} during the cycle
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic l, input logic e,
                                input logic [W-1:0] dd, input logic [3:0] exp);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.dd = dd; v.exp = exp;
        return v;
    endfunction

    function automatic logic [3:0] model_out(input logic e);
        if (mq.size() > 0) return {mq[0], e, 1'b1, 1'b0};
        if (done_pend)     return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic model_edge(input logic r, input logic l, input logic e,
                              input logic [W-1:0] dd);
        if (r) begin
            mq.delete();
            done_pend   = 1'b0;
            model_valid = 1'b1;
        end else if (mq.size() > 0) begin
            if (e) begin
                void'(mq.pop_front());
                if (mq.size() == 0) done_pend = 1'b1;
            end
        end else begin
            done_pend = 1'b0;
            if (l) begin
                for (int i = W - 1; i >= 0; i--) mq.push_back(dd[i]);
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: so/sv/busy/done got %b expected %b at %0t", name, act, exp,
                      $time);
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic [W-1:0] dd,
                        input bit use_exp, input logic [3:0] exp, input string name);
        @(negedge ck);
        res = r; ld = l; en = e; d = dd;
        #1;
        if (model_valid) check({name, "/model"}, {so, sv, busy, done}, model_out(e));
        if (use_exp) check(name, {so, sv, busy, done}, exp);
        @(posedge ck);
        model_edge(r, l, e, dd);
    endtask

    initial begin
        res = 1'b0; ld = 1'b0; en = 1'b0; d = '0;

        // Basic word 1011 with en held high
        vecs.push_back(mk(0, 1, 1, 4'b1011, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));
        // Word 1100 with stalls: so holds, sv drops
        vecs.push_back(mk(0, 1, 0, 4'b1100, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b1010));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b1010));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000));
        // ld during SHIFT is ignored
        vecs.push_back(mk(0, 1, 1, 4'b1011, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 1, 1, 4'b0110, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0110, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 4'b0000));
        // Back-to-back 1001 then 0101 loaded in DONE
        vecs.push_back(mk(0, 1, 1, 4'b1001, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 1, 1, 4'b0101, 4'b0001));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0001));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));
        // Reset on third SHIFT edge of 1111: no done afterwards
        vecs.push_back(mk(0, 1, 1, 4'b1111, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(1, 0, 1, 4'b0000, 4'b1110));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));
        // res and ld together: reset wins
        vecs.push_back(mk(1, 1, 1, 4'b1010, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(0, 0, 1, 4'b0000, 4'b0000));

        step(1, 0, 0, '0, 1'b0, 4'b0000, "init_reset");
        step(1, 1, 1, 4'b1111, 1'b0, 4'b0000, "reset_hold");
        step(0, 0, 1, '0, 1'b1, 4'b0000, "reset_state");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].dd, 1'b1, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(49) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(3) != 0), W'($urandom), 1'b0, 4'b0000, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/par_seri_tx.md
PAR_SERI_TX -- requirements
Module: par_seri_tx

Interface
REQ-001 Parameter W SHALL default to 4 and set the parallel word width (W >= 2).
REQ-002 ck  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 res  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of ck.
REQ-004 en  input  1  SHALL be the shift enable; each shift advances one bit only on an edge where en=1.
REQ-005 ld  input  1  SHALL be the load request; it is accepted only in IDLE or DONE.
REQ-006 d  input  W  SHALL be the parallel data word, sampled on the accepting ld edge.
REQ-007 so  output  1  SHALL be the serial data output, MSB first.
REQ-008 sv  output  1  SHALL be the serial-valid strobe; the far-end receiver captures so on edges where sv=1.
REQ-009 busy  output  1  SHALL be high while a word is being shifted out.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking completion of a word.

Function
REQ-011 The block SHALL implement exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE outputs SHALL be so=0, sv=0, busy=0 and done=0.
REQ-013 In IDLE, an edge with ld=1 SHALL load d into a W-bit shift register, clear the bit counter and enter SHIFT.
REQ-014 In SHIFT, so SHALL equal shift register bit W-1, busy SHALL be 1, and sv SHALL equal en combinationally.
REQ-015 In SHIFT, an edge with en=1 SHALL shift the register left by one (LSB filled with 0) and increment the counter.
REQ-016 In SHIFT, an edge with en=0 SHALL hold the register, counter and state, and so SHALL stay stable.
REQ-017 In SHIFT, an edge with en=1 and counter=W-1 SHALL enter DONE instead of incrementing.
REQ-018 The counter SHALL be ceil(log2 W) bits wide and SHALL never exceed W-1.
REQ-019 DONE SHALL last exactly one cycle with done=1, busy=0, sv=0 and so=0.
REQ-020 From DONE, ld=1 SHALL load d and enter SHIFT (back-to-back words with no idle gap); otherwise the next state SHALL be IDLE.
REQ-021 ld SHALL be ignored in SHIFT; the in-flight word and d sampling SHALL NOT be affected.
REQ-022 en SHALL be ignored in IDLE and DONE.
REQ-023 With en held at 1, the first bit SHALL appear on so in the cycle after the load edge, and done SHALL assert W cycles after that first-bit cycle.
REQ-024 Exactly W sv=1 edges SHALL occur per loaded word, carrying d[W-1] down to d[0] in order.

Reset
REQ-025 An edge with res=1 SHALL force IDLE, clear the shift register and counter, and drive so=0, sv=0, busy=0 and done=0 from the next cycle.
REQ-026 res SHALL have priority over ld and en on the same edge.
REQ-027 res during SHIFT SHALL abandon the word; no done pulse SHALL follow.
REQ-028 Before the first reset edge, outputs are undefined; benches SHALL assert res for at least one edge.

Verification
REQ-029 W=4, reset, then ld=1 with d=1011 and en=1 continuously -> so=1,0,1,1 on four consecutive cycles with sv=1 and busy=1; done=1 on the fifth cycle; then IDLE.
REQ-030 d=1100 with en pattern 1,0,0,1,1,1 -> so holds its value through the en=0 cycles, sv=0 in those cycles, and exactly four sv=1 bits 1,1,0,0 are sent before done.
REQ-031 ld=1 with d=0110 asserted on the second SHIFT cycle of word 1011 -> transmitted bits remain 1,0,1,1; 0110 is not sent.
REQ-032 ld=1 with d=0101 held in the DONE cycle after word 1001 -> bits 1,0,0,1 are followed immediately by 0,1,0,1 with no IDLE cycle; done pulses twice.
REQ-033 res=1 on the third SHIFT edge of word 1111 -> IDLE next cycle, so=0, busy=0, and no done pulse.
REQ-034 res=1 and ld=1 on the same edge -> block stays in IDLE and busy stays 0.
